// File: rtl/mem_load_check.sv
// mem_load_check: preload / run / check sequencer for one CPU memory port.
// Optional watchdog: define LOADCHK_TIMEOUT_EN.
module mem_load_check #(
    parameter int          DATA_W     = 64,
    parameter int          ADDR_W     = 64,
    parameter int          DEPTH      = 1024,
    parameter int          BYTE_SHIFT = 3,
    parameter int          RD_LAT     = 1,
    parameter logic [6:0]  STOP_OP    = 7'b1111110,
    parameter int          CYC_W      = 32,
    parameter int          TIMEOUT    = 2**20,
    localparam int         IDX_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  load_len,
    input  logic [IDX_W-1:0]  chk_base,
    input  logic [IDX_W-1:0]  chk_len,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [31:0]       instr,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err,
    output logic [3:0]        test_id,
    output logic [CYC_W-1:0]  cycles,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_load_len;
    logic [IDX_W-1:0]   r_chk_base;
    logic [IDX_W-1:0]   r_chk_len;
    logic [IDX_W-1:0]   r_load_idx;
    logic [IDX_W-1:0]   r_chk_idx;
    logic [CYC_W-1:0]   r_cycles;
    logic [3:0]         r_test_id;
    logic [IDX_W-1:0]   r_err_count;
    logic [IDX_W-1:0]   r_first_err;
    logic               r_pass;
    logic               r_done;

    logic [RD_LAT-1:0]  r_dl_vld;
    logic [DATA_W-1:0]  r_dl_exp [RD_LAT];
    logic [IDX_W-1:0]   r_dl_idx [RD_LAT];

    logic               w_stop;
    logic               w_mis;
    logic [IDX_W-1:0]   w_err_nxt;
    logic               w_dl_pend;
    logic [ADDR_W-1:0]  w_chk_word;
    logic               w_unused;

`ifdef LOADCHK_TIMEOUT_EN
    logic               r_timeout;
    logic               w_wdog;
    assign w_wdog  = (r_cycles + CYC_W'(1)) == CYC_W'(TIMEOUT);
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign w_unused   = (^instr[27:7]) ^ (TIMEOUT == 0);
    assign w_stop     = instr[6:0] == STOP_OP;
    assign w_chk_word = ADDR_W'(r_chk_base) + ADDR_W'(r_chk_idx);

    // Compare the oldest delay-line entry against returning read data
    assign w_mis = r_dl_vld[RD_LAT-1] && (mem_rdata != r_dl_exp[RD_LAT-1]);
    assign w_err_nxt = (w_mis && (r_err_count != '1)) ?
                       r_err_count + IDX_W'(1) : r_err_count;

    // Entries still ahead of the compare stage keep DRAIN waiting
    always_comb begin
        w_dl_pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            w_dl_pend = w_dl_pend | r_dl_vld[i];
        end
    end

    assign busy       = r_state != S_IDLE;
    assign cpu_enable = r_state == S_RUN;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_err  = r_first_err;
    assign test_id    = r_test_id;
    assign cycles     = r_cycles;

    // Memory port and stream handshakes decoded from state and counters
    always_comb begin
        src_ready = 1'b0;
        exp_ready = 1'b0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_LOAD: begin
                src_ready = 1'b1;
                mem_wen   = src_valid;
                mem_wdata = src_data;
                mem_addr  = ADDR_W'(r_load_idx) << BYTE_SHIFT;
            end
            S_CHECK: begin
                exp_ready = exp_valid;
                mem_ren   = exp_valid;
                mem_addr  = w_chk_word << BYTE_SHIFT;
            end
            default: begin
            end
        endcase
    end

    // Expected data and index ride alongside the memory read latency
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_dl_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dl_exp[i] <= '0;
                r_dl_idx[i] <= '0;
            end
        end else begin
            r_dl_vld[0] <= (r_state == S_CHECK) && exp_valid;
            r_dl_exp[0] <= exp_data;
            r_dl_idx[0] <= r_chk_base + r_chk_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_exp[i] <= r_dl_exp[i-1];
                r_dl_idx[i] <= r_dl_idx[i-1];
            end
        end
    end

    // Sequencer FSM with result status registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_load_len  <= '0;
            r_chk_base  <= '0;
            r_chk_len   <= '0;
            r_load_idx  <= '0;
            r_chk_idx   <= '0;
            r_cycles    <= '0;
            r_test_id   <= '0;
            r_err_count <= '0;
            r_first_err <= '1;
            r_pass      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADCHK_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_err_count <= w_err_nxt;
            if (w_mis && (r_err_count == '0)) begin
                r_first_err <= r_dl_idx[RD_LAT-1];
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_load_len  <= load_len;
                        r_chk_base  <= chk_base;
                        r_chk_len   <= chk_len;
                        r_load_idx  <= '0;
                        r_chk_idx   <= '0;
                        r_cycles    <= '0;
                        r_test_id   <= '0;
                        r_err_count <= '0;
                        r_first_err <= '1;
                        r_pass      <= 1'b0;
`ifdef LOADCHK_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                        r_state <= (load_len == '0) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (src_valid) begin
                        r_load_idx <= r_load_idx + IDX_W'(1);
                        if (r_load_idx + IDX_W'(1) == r_load_len) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_cycles <= r_cycles + CYC_W'(1);
                    if (w_stop) begin
                        r_test_id <= instr[31:28];
                        if (r_chk_len == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
`ifdef LOADCHK_TIMEOUT_EN
                    else if (w_wdog) begin
                        r_timeout <= 1'b1;
                        if (r_chk_len == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b0;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
`endif
                end
                S_CHECK: begin
                    if (exp_valid) begin
                        r_chk_idx <= r_chk_idx + IDX_W'(1);
                        if (r_chk_idx + IDX_W'(1) == r_chk_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_dl_pend) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0) && !timeout;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
